// File: rtl/eth_frame_gen_pkg.sv
// Shared types and constants for the Ethernet frame generator.
// Frame-size limits, stream widths, FSM state encoding and the latched command record.
package global_types;

    localparam int unsigned ETH_HDR_BYTES   = 14;
    localparam int unsigned ETH_MIN_PAYLOAD = 46;
    localparam int unsigned ETH_MAX_PAYLOAD = 1500;

    localparam int unsigned STREAM_DATA_W  = 32;
    localparam int unsigned STREAM_EMPTY_W = 2;
    localparam int unsigned BEAT_W         = 9;
    localparam int unsigned LEN_W          = 11;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY
    } frame_gen_state_t;

    typedef struct packed {
        logic [47:0]      dst;
        logic [47:0]      src;
        logic [15:0]      etype;
        logic [LEN_W-1:0] len;
        logic [7:0]       seed;
    } frame_cmd_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len < LEN_W'(ETH_MIN_PAYLOAD)) return LEN_W'(ETH_MIN_PAYLOAD);
        if (len > LEN_W'(ETH_MAX_PAYLOAD)) return LEN_W'(ETH_MAX_PAYLOAD);
        return len;
    endfunction

endpackage

// File: rtl/eth_frame_gen_if.sv
// Avalon-ST source bundle carrying the out_* transmit stream.
interface avln_st #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
);
    logic [DATA_W-1:0]  out_data;
    logic               out_sop;
    logic               out_eop;
    logic [EMPTY_W-1:0] out_empty;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output out_data, out_sop, out_eop, out_empty, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_sop, out_eop, out_empty, out_valid,
        output out_ready
    );
endinterface

// File: rtl/eth_frame_gen_beat_pack.sv
// Combinational beat builder: beat index + latched command + payload index
// -> big-endian 32-bit word with lanes past end-of-frame zeroed, plus eop/empty.
module eth_beat_pack
    import global_types::*;
(
    input  logic [BEAT_W-1:0] beat_idx,
    input  frame_cmd_t        cmd,
    input  logic [7:0]        pay_idx,
    output logic [31:0]       data,
    output logic              eop,
    output logic [1:0]        empty
);

    logic [LEN_W-1:0]  total;
    logic [LEN_W-1:0]  byte_addr;
    logic [BEAT_W-1:0] last_beat;
    logic [95:0]       hdr_sh;
    logic [7:0]        lane;

    always_comb begin
        total     = LEN_W'(ETH_HDR_BYTES) + cmd.len;
        last_beat = BEAT_W'((total + LEN_W'(3)) >> 2) - BEAT_W'(1);
        eop       = (beat_idx == last_beat);
        empty     = 2'(LEN_W'(0) - total);
        data      = '0;
        byte_addr = '0;
        hdr_sh    = '0;
        lane      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            byte_addr = {beat_idx, 2'b00} + LEN_W'(k);
            hdr_sh    = {cmd.dst, cmd.src} << {byte_addr[3:0], 3'b000};
            if (beat_idx < BEAT_W'(3)) begin
                lane = hdr_sh[95:88];
            end else if (beat_idx == BEAT_W'(3)) begin
                if (k == 0)      lane = cmd.etype[15:8];
                else if (k == 1) lane = cmd.etype[7:0];
                else             lane = cmd.seed + pay_idx + 8'(k - 2);
            end else begin
                lane = cmd.seed + pay_idx + 8'(k);
            end
            if (byte_addr >= total) lane = '0;
            data = {data[23:0], lane};
        end
    end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet frame source: latches one command, streams header + incrementing
// payload as Avalon-ST beats under backpressure, counts completed frames.
module eth_frame_gen
    import global_types::*;
#(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [47:0] cmd_dst,
    input  logic [47:0] cmd_src,
    input  logic [15:0] cmd_type,
    input  logic [10:0] cmd_len,
    input  logic [7:0]  cmd_seed,
    avln_st.master      out_st,
    output logic        busy,
    output logic [15:0] frames_sent
);

    frame_gen_state_t   state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [7:0]         pay_q, pay_d;
    frame_cmd_t         cmd_q, cmd_d;
    logic [15:0]        frames_q, frames_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               valid_q, valid_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               load;
    logic               beat_fire;
    logic [31:0]        pk_data;
    logic               pk_eop;
    logic [1:0]         pk_empty;

    assign beat_fire = valid_q & out_st.out_ready;

    // The packer sees the *next* beat so the outputs can be registered.
    eth_beat_pack u_pack (
        .beat_idx (beat_d),
        .cmd      (cmd_d),
        .pay_idx  (pay_d),
        .data     (pk_data),
        .eop      (pk_eop),
        .empty    (pk_empty)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        pay_d    = pay_q;
        cmd_d    = cmd_q;
        frames_d = frames_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d   = '{dst: cmd_dst, src: cmd_src, etype: cmd_type,
                                len: clamp_len(cmd_len), seed: cmd_seed};
                    beat_d  = '0;
                    pay_d   = '0;
                    state_d = HDR;
                    load    = 1'b1;
                end
            end
            HDR, BODY: begin
                if (beat_fire) begin
                    if (eop_q) begin
                        state_d  = IDLE;
                        frames_d = frames_q + 16'd1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        if (beat_q == BEAT_W'(3))     pay_d = pay_q + 8'd2;
                        else if (beat_q > BEAT_W'(3)) pay_d = pay_q + 8'd4;
                        if (beat_q == BEAT_W'(2)) state_d = BODY;
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        empty_d     = empty_q;
        data_d      = data_q;
        cmd_ready_d = (state_d == IDLE);
        if (load) begin
            valid_d = 1'b1;
            sop_d   = (beat_d == '0);
            eop_d   = pk_eop;
            empty_d = pk_eop ? EMPTY_W'(pk_empty) : '0;
            data_d  = DATA_W'(pk_data);
        end else if (state_d == IDLE) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            empty_d = '0;
            data_d  = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            pay_q       <= '0;
            cmd_q       <= '0;
            frames_q    <= '0;
            cmd_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            empty_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            pay_q       <= pay_d;
            cmd_q       <= cmd_d;
            frames_q    <= frames_d;
            cmd_ready_q <= cmd_ready_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            empty_q     <= empty_d;
            data_q      <= data_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign busy             = (state_q != IDLE);
    assign frames_sent      = frames_q;
    assign out_st.out_data  = data_q;
    assign out_st.out_sop   = sop_q;
    assign out_st.out_eop   = eop_q;
    assign out_st.out_empty = empty_q;
    assign out_st.out_valid = valid_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed self-checking bench for eth_frame_gen: per-beat byte model plus
// hand-computed constants for the key beats, backpressure, clamping, reset abort.
module tb_eth_frame_gen;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_dst, cmd_src;
    logic [15:0] cmd_type;
    logic [10:0] cmd_len;
    logic [7:0]  cmd_seed;
    logic        busy;
    logic [15:0] frames_sent;

    avln_st #(.DATA_W(32), .EMPTY_W(2)) st ();

    eth_frame_gen #(.DATA_W(32), .EMPTY_W(2)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dst     (cmd_dst),
        .cmd_src     (cmd_src),
        .cmd_type    (cmd_type),
        .cmd_len     (cmd_len),
        .cmd_seed    (cmd_seed),
        .out_st      (st),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int fs_exp = 0;

    logic [31:0] b3, last;
    logic [1:0]  le;
    int          nb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [47:0] d, s, input logic [15:0] t,
                                              input int lc, input logic [7:0] seed, input int b);
        if (b >= 14 + lc) return 8'h00;
        if (b < 6)        return d[8*(5-b) +: 8];
        if (b < 12)       return s[8*(11-b) +: 8];
        if (b == 12)      return t[15:8];
        if (b == 13)      return t[7:0];
        return seed + 8'(b - 14);
    endfunction

    function automatic logic [31:0] exp_word(input logic [47:0] d, s, input logic [15:0] t,
                                             input int lc, input logic [7:0] seed, input int beat);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w = {w[23:0], model_byte(d, s, t, lc, seed, 4*beat + k)};
        return w;
    endfunction

    task automatic set_cmd(input logic [47:0] d, s, input logic [15:0] t,
                           input logic [10:0] l, input logic [7:0] sd);
        cmd_dst = d; cmd_src = s; cmd_type = t; cmd_len = l; cmd_seed = sd;
    endtask

    // Call at a negedge with cmd_valid high; returns just after the accepting edge.
    task automatic issue(input bit hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge sys_clk);
        end
        if (!ok) chk("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
        @(posedge sys_clk);
        #1;
        if (!hold) begin
            cmd_valid = 1'b0;
            set_cmd(~cmd_dst, ~cmd_src, ~cmd_type, 11'd3, ~cmd_seed);
        end
    endtask

    task automatic collect(input logic [47:0] d, s, input logic [15:0] t, input int lc,
                           input logic [7:0] seed, input bit rnd, input int abort_at,
                           output logic [31:0] beat3, output logic [31:0] lastw,
                           output logic [1:0] last_empty, output int nbeats);
        int          w_exp, emp, idx;
        bit          stalled, done, rdy;
        logic [63:0] snap;
        w_exp = (14 + lc + 3) / 4;
        emp   = (4 - ((14 + lc) % 4)) % 4;
        idx = 0; stalled = 0; done = 0;
        beat3 = '0; lastw = '0; last_empty = '0; snap = '0;
        for (int cyc = 0; cyc < 4*w_exp + 50 && !done; cyc++) begin
            @(negedge sys_clk);
            if (cyc == 0) begin
                chk("sop_latency", {62'd0, st.out_valid, st.out_sop}, 64'd3);
                chk("ready_busy_in_frame", {62'd0, cmd_ready, busy}, 64'd1);
            end
            if (stalled)
                chk("stall_hold", {27'd0, st.out_data, st.out_sop, st.out_eop, st.out_empty, st.out_valid}, snap);
            stalled = 0;
            if (abort_at >= 0 && idx == abort_at) begin
                nbeats = idx;
                return;
            end
            chk("valid_mid_frame", {63'd0, st.out_valid}, 64'd1);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            st.out_ready = rdy;
            if (rdy && st.out_valid) begin
                chk("beat_data", {32'd0, st.out_data}, {32'd0, exp_word(d, s, t, lc, seed, idx)});
                chk("beat_ctrl", {60'd0, st.out_sop, st.out_eop, st.out_empty},
                    {60'd0, idx == 0, idx == w_exp - 1, (idx == w_exp - 1) ? 2'(emp) : 2'd0});
                if (idx == 3) beat3 = st.out_data;
                if (st.out_eop || idx > w_exp + 2) begin
                    lastw = st.out_data;
                    last_empty = st.out_empty;
                    done = 1;
                end
                idx++;
            end else begin
                stalled = 1;
                snap = {27'd0, st.out_data, st.out_sop, st.out_eop, st.out_empty, st.out_valid};
            end
        end
        nbeats = idx;
        if (!done) chk("frame_timeout", {63'd0, done}, 64'd1);
        st.out_ready = 1'b1;
        @(negedge sys_clk);
        chk("post_eop_idle", {61'd0, cmd_ready, busy, st.out_valid}, 64'd4);
        fs_exp++;
        chk("frames_sent", {48'd0, frames_sent}, 64'(fs_exp));
    endtask

    logic [47:0] bd [3] = '{48'h0A0B0C0D0E0F, 48'h111111111111, 48'hFFEEDDCCBBAA};
    logic [47:0] bs [3] = '{48'h020000000001, 48'h222222222222, 48'h0123456789AB};
    logic [15:0] bt [3] = '{16'h0800, 16'h86DD, 16'h0806};
    int          bl [3] = '{46, 50, 47};
    logic [7:0]  bsd[3] = '{8'h10, 8'h80, 8'hF0};

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; st.out_ready = 1'b1;
        set_cmd('0, '0, '0, '0, '0);
        #1;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_ctrl", {58'd0, st.out_valid, st.out_sop, st.out_eop, st.out_empty, busy}, 64'd0);
        chk("rst_data", {32'd0, st.out_data}, 64'd0);
        chk("rst_frames", {48'd0, frames_sent}, 64'd0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Minimum frame, seed 0
        set_cmd(48'h001122334455, 48'h66778899AABB, 16'h0800, 11'd46, 8'h00);
        cmd_valid = 1'b1;
        issue(0);
        collect(48'h001122334455, 48'h66778899AABB, 16'h0800, 46, 8'h00, 0, -1, b3, last, le, nb);
        chk("len46_beats", 64'(nb), 64'd15);
        chk("len46_beat3", {32'd0, b3}, 64'h0800_0001);
        chk("len46_last", {32'd0, last}, 64'h2A2B2C2D);
        chk("len46_empty", {62'd0, le}, 64'd0);

        // Payload wrap past 0xFF, partial last beat
        set_cmd(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h88B5, 11'd47, 8'hFE);
        cmd_valid = 1'b1;
        issue(0);
        collect(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h88B5, 47, 8'hFE, 0, -1, b3, last, le, nb);
        chk("len47_beats", 64'(nb), 64'd16);
        chk("len47_beat3", {32'd0, b3}, 64'h88B5_FEFF);
        chk("len47_last", {32'd0, last}, 64'h2C000000);
        chk("len47_empty", {62'd0, le}, 64'd3);

        // Maximum frame with random backpressure
        set_cmd(48'h010203040506, 48'h0708090A0B0C, 16'h0800, 11'd1500, 8'h5A);
        cmd_valid = 1'b1;
        issue(0);
        collect(48'h010203040506, 48'h0708090A0B0C, 16'h0800, 1500, 8'h5A, 1, -1, b3, last, le, nb);
        chk("len1500_beats", 64'(nb), 64'd379);
        chk("len1500_empty", {62'd0, le}, 64'd2);

        // Clamping at both ends
        set_cmd(48'h0000000000AA, 48'h0000000000BB, 16'h1234, 11'd10, 8'h33);
        cmd_valid = 1'b1;
        issue(0);
        collect(48'h0000000000AA, 48'h0000000000BB, 16'h1234, 46, 8'h33, 0, -1, b3, last, le, nb);
        chk("clamp_low_beats", 64'(nb), 64'd15);
        set_cmd(48'h0000000000CC, 48'h0000000000DD, 16'h4321, 11'd2047, 8'h77);
        cmd_valid = 1'b1;
        issue(0);
        collect(48'h0000000000CC, 48'h0000000000DD, 16'h4321, 1500, 8'h77, 0, -1, b3, last, le, nb);
        chk("clamp_high_beats", 64'(nb), 64'd379);

        // Three back-to-back commands with cmd_valid held high
        set_cmd(bd[0], bs[0], bt[0], 11'(bl[0]), bsd[0]);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(i < 2);
            if (i < 2) set_cmd(bd[i+1], bs[i+1], bt[i+1], 11'(bl[i+1]), bsd[i+1]);
            collect(bd[i], bs[i], bt[i], bl[i], bsd[i], 0, -1, b3, last, le, nb);
            chk("b2b_beats", 64'(nb), 64'((14 + bl[i] + 3) / 4));
        end

        // Reset in the middle of a long frame
        set_cmd(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, 11'd1500, 8'h01);
        cmd_valid = 1'b1;
        issue(0);
        collect(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, 1500, 8'h01, 0, 100, b3, last, le, nb);
        chk("abort_point", 64'(nb), 64'd100);
        reset = 1'b1;
        #1;
        chk("abort_outs", {26'd0, st.out_data, st.out_valid, st.out_sop, st.out_eop, st.out_empty, busy, cmd_ready}, 64'd0);
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        fs_exp = 0;
        repeat (2) @(negedge sys_clk);
        chk("abort_idle", {61'd0, cmd_ready, busy, st.out_valid}, 64'd4);
        chk("abort_frames", {48'd0, frames_sent}, 64'd0);

        // Clean frame after the abort
        set_cmd(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'h0800, 11'd60, 8'hC0);
        cmd_valid = 1'b1;
        issue(0);
        collect(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'h0800, 60, 8'hC0, 0, -1, b3, last, le, nb);
        chk("after_abort_beats", 64'(nb), 64'd19);
        chk("after_abort_empty", {62'd0, le}, 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
